// File: rtl/demo_rst_seq.sv
// Reset sequencer: waits for PLL lock, holds all domains, then releases them
// lowest index first with a fixed stagger. Supports masked software re-reset.
module demo_rst_seq #(
    parameter int N_DOM        = 3,
    parameter int HOLD_CYC     = 10,
    parameter int STAGGER_CYC  = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pll_lock_i,
    input  logic             sw_rst_req_i,
    input  logic [N_DOM-1:0] sw_rst_mask_i,
    output logic [N_DOM-1:0] dom_rst_o,
    output logic             seq_done_o,
    output logic             timeout_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int MAX_HS  = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
    localparam int CNT_MAX = ((LOCK_TIMEOUT > MAX_HS) ? LOCK_TIMEOUT : MAX_HS) - 1;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYC - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N_DOM-1:0] tgt, tgt_nxt;
    logic [N_DOM-1:0] dom_rst, dom_nxt;
    logic             seq_done, done_nxt;
    logic             timeout, to_nxt;
    logic             lock_meta, lock_s;

    logic [N_DOM-1:0] pending, next_bit;
    logic             last_one;
    logic             sw_go;

    // Targets still held in reset; the lowest one is released next.
    assign pending  = tgt & dom_rst;
    assign next_bit = pending & (~pending + N_DOM'(1));
    assign last_one = ((pending & ~next_bit) == '0);
    assign sw_go    = sw_rst_req_i && (sw_rst_mask_i != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            state     <= WAIT_LOCK;
            cnt       <= '0;
            tgt       <= '1;
            dom_rst   <= '1;
            seq_done  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tgt       <= tgt_nxt;
            dom_rst   <= dom_nxt;
            seq_done  <= done_nxt;
            timeout   <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOCK: if (lock_s) state_nxt = HOLD;
            HOLD: begin
                if (!lock_s)                state_nxt = WAIT_LOCK;
                else if (cnt == HOLD_LAST)  state_nxt = last_one ? RUN : RELEASE;
            end
            RELEASE: begin
                if (!lock_s)                            state_nxt = WAIT_LOCK;
                else if (cnt == STAG_LAST && last_one)  state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s)     state_nxt = WAIT_LOCK;
                else if (sw_go)  state_nxt = HOLD;
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    always_comb begin
        cnt_nxt  = cnt;
        tgt_nxt  = tgt;
        dom_nxt  = dom_rst;
        done_nxt = seq_done;
        to_nxt   = timeout;
        if (state != WAIT_LOCK && !lock_s) begin
            // Lock loss overrides everything, including a same-cycle sw request.
            dom_nxt  = '1;
            done_nxt = 1'b0;
            cnt_nxt  = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (cnt == TO_LAST) to_nxt = 1'b1;
                    if (lock_s) begin
                        cnt_nxt = '0;
                        tgt_nxt = '1;
                    end else if (cnt != TO_LAST) begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        dom_nxt  = dom_rst & ~next_bit;
                        done_nxt = last_one;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == STAG_LAST) begin
                        dom_nxt  = dom_rst & ~next_bit;
                        done_nxt = last_one;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (sw_go) begin
                        dom_nxt  = dom_rst | sw_rst_mask_i;
                        tgt_nxt  = sw_rst_mask_i;
                        done_nxt = 1'b0;
                        cnt_nxt  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dom_rst_o  = dom_rst;
    assign seq_done_o = seq_done;
    assign timeout_o  = timeout;
    assign state_o    = state;

endmodule

// File: tb/tb_demo_rst_seq.sv
// Bench for demo_rst_seq: step tables with expected outputs queued at drive
// time and popped when outputs are sampled, plus async-reset sequences.
module tb_demo_rst_seq;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pll_lock = 1'b0;
    logic         sw_req = 1'b0;
    logic [N-1:0] sw_mask = '0;
    logic [N-1:0] dom_rst;
    logic         seq_done;
    logic         timeout;
    logic [1:0]   state;

    demo_rst_seq #(
        .N_DOM(N), .HOLD_CYC(10), .STAGGER_CYC(4), .LOCK_TIMEOUT(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pll_lock_i(pll_lock),
        .sw_rst_req_i(sw_req), .sw_rst_mask_i(sw_mask),
        .dom_rst_o(dom_rst), .seq_done_o(seq_done),
        .timeout_o(timeout), .state_o(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ncyc;
        logic         lock;
        logic         req;
        logic [N-1:0] mask;
        logic [N-1:0] dom;
        logic         done;
        logic [1:0]   st;
        logic         to;
    } step_t;

    typedef struct {
        logic [N-1:0] dom;
        logic         done;
        logic [1:0]   st;
        logic         to;
    } exp_t;

    exp_t  expq[$];
    step_t tbl[$];
    step_t tbl_to[$];
    int    n_chk = 0;
    int    n_fail = 0;

    function automatic step_t S(int n, logic l, logic r, logic [N-1:0] m,
                                logic [N-1:0] d, logic dn, logic [1:0] st, logic to);
        step_t s;
        s.ncyc = n; s.lock = l; s.req = r; s.mask = m;
        s.dom = d; s.done = dn; s.st = st; s.to = to;
        return s;
    endfunction

    task automatic check(input string name);
        exp_t e;
        if (expq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = expq.pop_front();
        n_chk++;
        if (dom_rst !== e.dom || seq_done !== e.done || state !== e.st || timeout !== e.to) begin
            n_fail++;
            $display("FAIL %s: got dom=%b done=%b st=%0d to=%b, want dom=%b done=%b st=%0d to=%b",
                     name, dom_rst, seq_done, state, timeout, e.dom, e.done, e.st, e.to);
        end
    endtask

    task automatic run_step(input step_t s, input string name);
        exp_t e;
        pll_lock = s.lock;
        sw_req   = s.req;
        sw_mask  = s.mask;
        e.dom = s.dom; e.done = s.done; e.st = s.st; e.to = s.to;
        expq.push_back(e);
        for (int i = 0; i < s.ncyc; i++) begin
            @(posedge clk);
            #1;
            sw_req  = 1'b0;
            sw_mask = '0;
        end
        check(name);
    endtask

    task automatic expect_reset(input string name);
        exp_t e;
        e.dom = '1; e.done = 1'b0; e.st = 2'd0; e.to = 1'b0;
        expq.push_back(e);
        check(name);
    endtask

    initial begin
        // Nominal bring-up (entries 0..7); comments give the edge after the step.
        tbl.push_back(S(2, 1, 0, 3'b000, 3'b111, 0, 2'd0, 0)); // 2
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b111, 0, 2'd1, 0)); // 3 HOLD
        tbl.push_back(S(9, 1, 0, 3'b000, 3'b111, 0, 2'd1, 0)); // 12
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b110, 0, 2'd2, 0)); // 13
        tbl.push_back(S(3, 1, 0, 3'b000, 3'b110, 0, 2'd2, 0)); // 16
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b100, 0, 2'd2, 0)); // 17
        tbl.push_back(S(3, 1, 0, 3'b000, 3'b100, 0, 2'd2, 0)); // 20
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 21 RUN
        tbl.push_back(S(5, 1, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 26
        // Partial re-reset of domains 1,2
        tbl.push_back(S(1, 1, 1, 3'b110, 3'b110, 0, 2'd1, 0)); // 27
        tbl.push_back(S(9, 1, 0, 3'b000, 3'b110, 0, 2'd1, 0)); // 36
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b100, 0, 2'd2, 0)); // 37
        tbl.push_back(S(3, 1, 0, 3'b000, 3'b100, 0, 2'd2, 0)); // 40
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 41
        // Mask-0 request ignored
        tbl.push_back(S(1, 1, 1, 3'b000, 3'b000, 1, 2'd3, 0)); // 42
        tbl.push_back(S(2, 1, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 44
        // Single target: HOLD straight to RUN
        tbl.push_back(S(1, 1, 1, 3'b010, 3'b010, 0, 2'd1, 0)); // 45
        tbl.push_back(S(9, 1, 0, 3'b000, 3'b010, 0, 2'd1, 0)); // 54
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 55
        // Request during HOLD ignored, counter not restarted
        tbl.push_back(S(1, 1, 1, 3'b100, 3'b100, 0, 2'd1, 0)); // 56
        tbl.push_back(S(3, 1, 0, 3'b000, 3'b100, 0, 2'd1, 0)); // 59
        tbl.push_back(S(1, 1, 1, 3'b011, 3'b100, 0, 2'd1, 0)); // 60
        tbl.push_back(S(5, 1, 0, 3'b000, 3'b100, 0, 2'd1, 0)); // 65
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 66
        // Sw request coincident with lock_s falling: lock loss wins
        tbl.push_back(S(1, 0, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 67
        tbl.push_back(S(1, 0, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 68
        tbl.push_back(S(1, 0, 1, 3'b001, 3'b111, 0, 2'd0, 0)); // 69
        // Relock, then lock loss during RELEASE
        tbl.push_back(S(2, 1, 0, 3'b000, 3'b111, 0, 2'd0, 0)); // 71
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b111, 0, 2'd1, 0)); // 72
        tbl.push_back(S(10, 1, 0, 3'b000, 3'b110, 0, 2'd2, 0)); // 82
        tbl.push_back(S(1, 0, 0, 3'b000, 3'b110, 0, 2'd2, 0)); // 83
        tbl.push_back(S(1, 0, 0, 3'b000, 3'b110, 0, 2'd2, 0)); // 84
        tbl.push_back(S(1, 0, 0, 3'b000, 3'b111, 0, 2'd0, 0)); // 85
        // Full sequence after relock
        tbl.push_back(S(2, 1, 0, 3'b000, 3'b111, 0, 2'd0, 0)); // 87
        tbl.push_back(S(1, 1, 0, 3'b000, 3'b111, 0, 2'd1, 0)); // 88
        tbl.push_back(S(10, 1, 0, 3'b000, 3'b110, 0, 2'd2, 0)); // 98
        tbl.push_back(S(4, 1, 0, 3'b000, 3'b100, 0, 2'd2, 0)); // 102
        tbl.push_back(S(4, 1, 0, 3'b000, 3'b000, 1, 2'd3, 0)); // 106

        // Lock timeout with LOCK_TIMEOUT=16, then late lock
        tbl_to.push_back(S(15, 0, 0, 3'b000, 3'b111, 0, 2'd0, 0));
        tbl_to.push_back(S(1, 0, 0, 3'b000, 3'b111, 0, 2'd0, 1));
        tbl_to.push_back(S(20, 0, 0, 3'b000, 3'b111, 0, 2'd0, 1));
        tbl_to.push_back(S(2, 1, 0, 3'b000, 3'b111, 0, 2'd0, 1));
        tbl_to.push_back(S(1, 1, 0, 3'b000, 3'b111, 0, 2'd1, 1));
        tbl_to.push_back(S(10, 1, 0, 3'b000, 3'b110, 0, 2'd2, 1));
        tbl_to.push_back(S(4, 1, 0, 3'b000, 3'b100, 0, 2'd2, 1));
        tbl_to.push_back(S(4, 1, 0, 3'b000, 3'b000, 1, 2'd3, 1));

        #1 rst = 1'b1;
        #2 expect_reset("reset");
        #19 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run_step(tbl[i], $sformatf("main[%0d]", i));

        // Async reset mid-HOLD, then a clean restart
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        run_step(tbl[0], "arst_pre0");
        run_step(tbl[1], "arst_pre1");
        run_step(S(4, 1, 0, 3'b000, 3'b111, 0, 2'd1, 0), "arst_hold");
        #2 rst = 1'b1;
        #1 expect_reset("arst_async");
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++)
            run_step(tbl[i], $sformatf("arst_restart[%0d]", i));

        pll_lock = 1'b0;
        #2 rst = 1'b1;
        #1 expect_reset("to_reset");
        #2 rst = 1'b0;
        for (int i = 0; i < tbl_to.size(); i++)
            run_step(tbl_to[i], $sformatf("timeout[%0d]", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
